// File: rtl/sar_logic.sv
// Successive-approximation controller: samples, fires the comparator clock per bit,
// resolves the DAC trial code MSB-first and strobes the finished result.
module sar_logic #(
  parameter int NBITS       = 8,
  parameter int SAMPLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             vop,
  input  logic             done,
  output logic             cmp_clk,
  output logic             sample,
  output logic [NBITS-1:0] dac_code,
  output logic [NBITS-1:0] dout,
  output logic             valid,
  output logic             busy,
  output logic             meta
);

  localparam int          IW        = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [IW-1:0] IDX_MSB = IW'(NBITS - 1);
  localparam logic [7:0]  SAMP_LAST = 8'(SAMPLE_CYC - 1);
  localparam logic [7:0]  TO_LAST   = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_COMPARE,
    ST_RESET,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NBITS-1:0] dac_q, dac_d;
  logic [NBITS-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             meta_q, meta_d;
  logic             cmp_clk_q, cmp_clk_d;
  logic             sample_q, sample_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    dac_d     = dac_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    meta_d    = meta_q;
    cmp_clk_d = cmp_clk_q;
    sample_d  = sample_q;

    unique case (state_q)
      ST_IDLE: begin
        cmp_clk_d = 1'b0;
        sample_d  = 1'b0;
        if (start) begin
          state_d  = ST_SAMPLE;
          cnt_d    = '0;
          dac_d    = '0;
          meta_d   = 1'b0;
          sample_d = 1'b1;
        end
      end

      ST_SAMPLE: begin
        sample_d = 1'b1;
        if (cnt_q == SAMP_LAST) begin
          state_d          = ST_COMPARE;
          sample_d         = 1'b0;
          idx_d            = IDX_MSB;
          dac_d[NBITS-1]   = 1'b1;
          cmp_clk_d        = 1'b1;
          cnt_d            = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_COMPARE: begin
        cmp_clk_d = 1'b1;
        if (done) begin
          dac_d[idx_q] = vop;
          cmp_clk_d    = 1'b0;
          cnt_d        = '0;
          state_d      = ST_RESET;
        end else if (cnt_q == TO_LAST) begin
          // Timed-out bit is kept as 1; counter restarts so RESET gets its own full timeout window.
          dac_d[idx_q] = 1'b1;
          meta_d       = 1'b1;
          cmp_clk_d    = 1'b0;
          cnt_d        = '0;
          state_d      = ST_RESET;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_RESET: begin
        cmp_clk_d = 1'b0;
        if (!done || cnt_q == TO_LAST) begin
          if (done) meta_d = 1'b1;
          cnt_d = '0;
          if (idx_q == '0) begin
            state_d = ST_DONE;
            valid_d = 1'b1;
            dout_d  = dac_q;
          end else begin
            idx_d        = idx_q - IW'(1);
            dac_d[idx_d] = 1'b1;
            cmp_clk_d    = 1'b1;
            state_d      = ST_COMPARE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= IDX_MSB;
      dac_q     <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      meta_q    <= 1'b0;
      cmp_clk_q <= 1'b0;
      sample_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      dac_q     <= dac_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      meta_q    <= meta_d;
      cmp_clk_q <= cmp_clk_d;
      sample_q  <= sample_d;
    end
  end

  assign cmp_clk  = cmp_clk_q;
  assign sample   = sample_q;
  assign dac_code = dac_q;
  assign dout     = dout_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign meta     = meta_q;

endmodule

// File: doc/sar_logic.md
# sar_logic

Synchronous successive-approximation controller for the SAR-ADC model. It sits directly downstream of the sense amplifier: it fires the comparator clock, waits for the comparator's `done`, and captures the `vop` decision. It then updates the capacitor-DAC trial code MSB-first and delivers an `NBITS`-wide result with a one-cycle valid strobe.

## Interface
- `NBITS`, 8: conversion resolution in bits (2..16).
- `SAMPLE_CYC`, 2: clock cycles spent in the sampling phase (1..255).
- `TIMEOUT_CYC`, 4: maximum cycles to wait on a `done` edge before forcing progress (1..255).

Ports:
- `clk` input 1: system clock. All logic is rising-edge.
- `rstn` input 1: reset, synchronous, active-low.
- `start` input 1: conversion request. Accepted only in IDLE.
- `vop` input 1: sense-amp positive output. 1 means vip+offset ≥ vin+offset.
- `done` input 1: sense-amp decision-complete flag.
- `cmp_clk` output 1: comparator clock. Drives the sense-amp `asyn_clk`.
- `sample` output 1: bootstrap/sample switch enable.
- `dac_code` output NBITS: current trial code to the capacitor DAC.
- `dout` output NBITS: last completed conversion result.
- `valid` output 1: one-cycle strobe; `dout` updated this cycle.
- `busy` output 1: high whenever the state is not IDLE.
- `meta` output 1: sticky; set if any timeout occurred in the current conversion.

## Operation
States: IDLE, SAMPLE, COMPARE, RESET, DONE. Outputs are registered. Internal registers:
- bit index `idx` (NBITS-1 down to 0)
- cycle counter `cnt` (8 bits)

Transitions:
- **IDLE**
  - `cmp_clk`=0, `sample`=0, `busy`=0.
  - If `start`=1: go to SAMPLE. Set `cnt`=0, `dac_code`=0, `meta`=0.
- **SAMPLE**
  - `sample`=1 and `cnt` increments each cycle.
  - When `cnt`=SAMPLE_CYC-1:
    - go to COMPARE
    - `sample`←0, `idx`←NBITS-1
    - `dac_code[NBITS-1]`←1 (trial)
    - `cmp_clk`←1, `cnt`←0.
- **COMPARE**
  - `cmp_clk` held 1.
  - If `done`=1:
    - `dac_code[idx]`←`vop`
    - `cmp_clk`←0, `cnt`←0
    - go to RESET.
  - Else if `cnt`=TIMEOUT_CYC-1:
    - `dac_code[idx]`←1
    - `meta`←1
    - `cmp_clk`←0
    - go to RESET.
  - Otherwise `cnt`++.
- **RESET**
  - `cmp_clk` held 0.
  - Exit condition: `done`=0, or `cnt`=TIMEOUT_CYC-1 (the timeout case also sets `meta`←1).
  - On exit with `idx`=0: go to DONE.
  - On exit with `idx`>0:
    - `idx`←`idx`-1
    - `dac_code[idx-1]`←1 (trial)
    - `cmp_clk`←1, `cnt`←0
    - go to COMPARE.
  - Otherwise `cnt`++.
- **DONE**
  - `dout`←`dac_code`, `valid`=1 for this single cycle.
  - Go to IDLE. `dac_code` holds its value until the next start.

Rules:
- Bits already decided are never modified.
- Bits below `idx` stay 0 until they are trialled.
- `start` outside IDLE (including DONE) is ignored. It is not queued.
- `vop` is sampled only in the cycle `done` is seen high. `von` is not used.

Reset values (`rstn`=0 at a rising edge, from any state):
- state=IDLE
- `cmp_clk`=0, `sample`=0, `dac_code`=0, `dout`=0, `valid`=0, `busy`=0, `meta`=0
- `cnt`=0, `idx`=NBITS-1

A reset mid-conversion discards the partial result. `dout` returns to 0.

## Timing
- `start` captured at edge E0; `busy`=1 from E0.
- `sample`=1 from E0 to E0+SAMPLE_CYC.
- With an ideal comparator (`done` rises within the `cmp_clk`-high cycle and falls within the `cmp_clk`-low cycle):
  - each bit costs exactly 2 cycles: COMPARE then RESET.
  - `cmp_clk` is a 50% square pulse per bit.
- MSB `cmp_clk` rises at E0+SAMPLE_CYC.
- `valid`=1 in the cycle after E0+SAMPLE_CYC+2·NBITS; IDLE is reached the edge after that.
- Total start-to-valid latency: SAMPLE_CYC+2·NBITS+1 edges. NBITS=8, SAMPLE_CYC=2 gives 19.
- Each timeout adds up to TIMEOUT_CYC-1 cycles per affected phase.
- Back-to-back: `start` held high re-triggers on the first IDLE cycle, one cycle after `valid`.
- `done` and `vop` are treated as settled before the next rising edge; no synchronizer is required in the model.

## Test plan
- **Ideal conversion.** Bench comparator resolves against a target code 8'hA5 (NBITS=8, SAMPLE_CYC=2) → `dac_code` trial sequence 80, C0→80, A0, B0→A0, A8→A0, A4, A6→A4, A5; `dout`=8'hA5, `valid` at edge 19, `meta`=0.
- **Extremes.** Target 8'h00 and 8'hFF → `dout` 00 / FF; exactly 8 `cmp_clk` pulses each.
- **Timeout.** `done` held 0 for the MSB only, TIMEOUT_CYC=4 → MSB forced 1, `meta`=1, conversion completes 3 cycles late; the next conversion clears `meta`.
- **Stuck done.** `done` held 1 during one RESET → RESET exits after 4 cycles, `meta`=1, bits still correct for the remaining decisions.
- **Reset mid-conversion.** `rstn`=0 at bit 4 → next edge: all outputs 0, state IDLE, no `valid`; a fresh `start` converts normally.
- **Start while busy.** `start` pulses during COMPARE and DONE → ignored; only one `valid`; `start` held high gives back-to-back conversions one idle cycle apart.
